// File: rtl/alu_pipe_if.sv
// Handshake bundle between the register-read stage, the pipelined ALU and writeback.
// The slave modport is the ALU's view; the master modport is the driver/consumer's view.
interface alu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FUNC_WIDTH = 4
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic [FUNC_WIDTH-1:0] func_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  zero_o;
  logic                  carry_o;
  logic                  invalid_o;

  modport slave (
    input  in_valid_i, rs1_data_i, rs2_data_i, func_i, rd_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, rd_data_o, rd_addr_o, zero_o, carry_o, invalid_o
  );

  modport master (
    output in_valid_i, rs1_data_i, rs2_data_i, func_i, rd_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, rd_data_o, rd_addr_o, zero_o, carry_o, invalid_o
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU: S1 captures operands, S2 holds result and flags.
// Both stages use valid/ready so a stalled writeback backs up into the decode stage.
module alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FUNC_WIDTH = 4
) (
  input logic       clk_i,
  input logic       arst_ni,
  alu_pipe_if.slave bus
);

  localparam int ShW = $clog2(DATA_WIDTH);

  localparam logic [FUNC_WIDTH-1:0] OpAnd  = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] OpOr   = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] OpXor  = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] OpNot  = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] OpAdd  = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] OpSub  = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] OpSll  = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] OpSrl  = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] OpSra  = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] OpSlt  = FUNC_WIDTH'(9);
  localparam logic [FUNC_WIDTH-1:0] OpSltu = FUNC_WIDTH'(10);

  logic                  s1Valid_q, s1Valid_d;
  logic [DATA_WIDTH-1:0] s1Rs1_q, s1Rs1_d;
  logic [DATA_WIDTH-1:0] s1Rs2_q, s1Rs2_d;
  logic [FUNC_WIDTH-1:0] s1Func_q, s1Func_d;
  logic [ADDR_WIDTH-1:0] s1Rd_q, s1Rd_d;

  logic                  s2Valid_q, s2Valid_d;
  logic [DATA_WIDTH-1:0] s2Data_q, s2Data_d;
  logic [ADDR_WIDTH-1:0] s2Rd_q, s2Rd_d;
  logic                  s2Zero_q, s2Zero_d;
  logic                  s2Carry_q, s2Carry_d;
  logic                  s2Invalid_q, s2Invalid_d;

  logic                  s2Free;
  logic                  s1Advance;
  logic                  inReady;
  logic                  inXfer;

  logic [DATA_WIDTH-1:0] aluResult;
  logic                  aluCarry;
  logic                  aluInvalid;
  logic [DATA_WIDTH:0]   addSum;
  logic [ShW-1:0]        shamt;

  // S2 frees up when it is empty or being drained; in_ready_o depends on out_ready_i.
  always_comb begin
    s2Free    = !s2Valid_q || bus.out_ready_i;
    s1Advance = s1Valid_q && s2Free;
    inReady   = !s1Valid_q || s2Free;
    inXfer    = bus.in_valid_i && inReady;
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Rs1_d   = s1Rs1_q;
    s1Rs2_d   = s1Rs2_q;
    s1Func_d  = s1Func_q;
    s1Rd_d    = s1Rd_q;
    if (inXfer) begin
      s1Valid_d = 1'b1;
      s1Rs1_d   = bus.rs1_data_i;
      s1Rs2_d   = bus.rs2_data_i;
      s1Func_d  = bus.func_i;
      s1Rd_d    = bus.rd_addr_i;
    end else if (s1Advance) begin
      s1Valid_d = 1'b0;
    end
  end

  always_comb begin
    aluResult  = '0;
    aluCarry   = 1'b0;
    aluInvalid = 1'b0;
    shamt      = s1Rs2_q[ShW-1:0];
    addSum     = {1'b0, s1Rs1_q} + {1'b0, s1Rs2_q};
    case (s1Func_q)
      OpAnd:  aluResult = s1Rs1_q & s1Rs2_q;
      OpOr:   aluResult = s1Rs1_q | s1Rs2_q;
      OpXor:  aluResult = s1Rs1_q ^ s1Rs2_q;
      OpNot:  aluResult = ~s1Rs1_q;
      OpAdd: begin
        aluResult = addSum[DATA_WIDTH-1:0];
        aluCarry  = addSum[DATA_WIDTH];
      end
      OpSub: begin
        aluResult = s1Rs1_q - s1Rs2_q;
        aluCarry  = (s1Rs1_q < s1Rs2_q);
      end
      OpSll:  aluResult = s1Rs1_q << shamt;
      OpSrl:  aluResult = s1Rs1_q >> shamt;
      OpSra:  aluResult = $signed(s1Rs1_q) >>> shamt;
      OpSlt:  aluResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(s1Rs1_q) < $signed(s1Rs2_q))};
      OpSltu: aluResult = {{(DATA_WIDTH-1){1'b0}}, (s1Rs1_q < s1Rs2_q)};
      default: aluInvalid = 1'b1;
    endcase
  end

  // S2 holds everything while stalled so writeback sees a stable result.
  always_comb begin
    s2Valid_d   = s2Valid_q;
    s2Data_d    = s2Data_q;
    s2Rd_d      = s2Rd_q;
    s2Zero_d    = s2Zero_q;
    s2Carry_d   = s2Carry_q;
    s2Invalid_d = s2Invalid_q;
    if (s1Advance) begin
      s2Valid_d   = 1'b1;
      s2Data_d    = aluResult;
      s2Rd_d      = s1Rd_q;
      s2Zero_d    = (aluResult == '0);
      s2Carry_d   = aluCarry;
      s2Invalid_d = aluInvalid;
    end else if (bus.out_ready_i) begin
      s2Valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      s1Valid_q   <= 1'b0;
      s1Rs1_q     <= '0;
      s1Rs2_q     <= '0;
      s1Func_q    <= '0;
      s1Rd_q      <= '0;
      s2Valid_q   <= 1'b0;
      s2Data_q    <= '0;
      s2Rd_q      <= '0;
      s2Zero_q    <= 1'b0;
      s2Carry_q   <= 1'b0;
      s2Invalid_q <= 1'b0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Rs1_q     <= s1Rs1_d;
      s1Rs2_q     <= s1Rs2_d;
      s1Func_q    <= s1Func_d;
      s1Rd_q      <= s1Rd_d;
      s2Valid_q   <= s2Valid_d;
      s2Data_q    <= s2Data_d;
      s2Rd_q      <= s2Rd_d;
      s2Zero_q    <= s2Zero_d;
      s2Carry_q   <= s2Carry_d;
      s2Invalid_q <= s2Invalid_d;
    end
  end

  assign bus.in_ready_o  = inReady;
  assign bus.out_valid_o = s2Valid_q;
  assign bus.rd_data_o   = s2Data_q;
  assign bus.rd_addr_o   = s2Rd_q;
  assign bus.zero_o      = s2Zero_q;
  assign bus.carry_o     = s2Carry_q;
  assign bus.invalid_o   = s2Invalid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe: a reference model fills a scoreboard queue
// on every accepted input and a negedge monitor pops it on every output transfer.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        zero;
    logic        carry;
    logic        invalid;
  } expT;

  logic clk;
  logic arstN;
  int   nAsserts;
  int   nFails;
  int   popCount;
  int   cycleCnt;
  bit   randMode;
  expT  sbQueue[$];
  int   outCycles[$];

  alu_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FUNC_WIDTH(4)) bus ();

  alu_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FUNC_WIDTH(4)) dut (
    .clk_i   (clk),
    .arst_ni (arstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic expT model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
    expT         e;
    logic [32:0] s;
    logic [31:0] r;
    int          sh;
    e  = '0;
    r  = '0;
    s  = '0;
    sh = int'(b[4:0]);
    case (f)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~a;
      4'd4: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        e.carry = s[32];
      end
      4'd5: begin
        r = a - b;
        e.carry = (a < b);
      end
      4'd6: r = a << sh;
      4'd7: r = a >> sh;
      4'd8: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      end
      4'd9:  r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      4'd10: r = {31'b0, (a < b)};
      default: e.invalid = 1'b1;
    endcase
    e.data = r;
    e.rd   = rd;
    e.zero = (r == 32'h0);
    return e;
  endfunction

  task automatic checkBits(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compares each output transfer against the oldest outstanding model result.
  always @(negedge clk) begin
    if (arstN && bus.out_valid_o && bus.out_ready_i) begin
      checkBits("sb_not_empty", 64'(sbQueue.size() != 0), 64'(1));
      if (sbQueue.size() != 0) begin
        checkBits("sb_result",
                  64'({bus.rd_data_o, bus.rd_addr_o, bus.zero_o, bus.carry_o, bus.invalid_o}),
                  64'(sbQueue.pop_front()));
      end
      popCount++;
      outCycles.push_back(cycleCnt);
    end
  end

  task automatic syncUp();
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    bit accepted;
    bit rdy;
    accepted = 1'b0;
    bus.func_i     = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      rdy = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        sbQueue.push_back(model(f, a, b, rd));
      end
      if (randMode) bus.out_ready_i = 1'($urandom_range(0, 1));
    end
    bus.in_valid_i = 1'b0;
    checkBits("accept_in_time", 64'(accepted), 64'(1));
  endtask

  task automatic checkOutput(input string tag, input logic [39:0] exp);
    @(negedge clk);
    checkBits({tag, "_latency"}, 64'(bus.out_valid_o), 64'(0));
    @(negedge clk);
    checkBits({tag, "_valid"}, 64'(bus.out_valid_o), 64'(1));
    checkBits(tag, 64'({bus.rd_data_o, bus.rd_addr_o, bus.zero_o, bus.carry_o, bus.invalid_o}),
              64'(exp));
    syncUp();
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    nAsserts = 0;
    nFails   = 0;
    popCount = 0;
    randMode = 1'b0;
    arstN    = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.func_i      = '0;
    bus.rd_addr_i   = '0;
    bus.out_ready_i = 1'b1;

    #2;
    checkBits("reset_outputs", 64'({bus.out_valid_o, bus.rd_data_o, bus.rd_addr_o,
                                    bus.zero_o, bus.carry_o, bus.invalid_o}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    arstN = 1'b1;
    #1;
    checkBits("post_reset_ready_valid", 64'({bus.in_ready_o, bus.out_valid_o}), 64'(2'b10));
    syncUp();

    applyStimulus(4'd4, 32'hFFFF_FFFF, 32'h1, 5'd3);
    checkOutput("add_wrap", {32'h0, 5'd3, 1'b1, 1'b1, 1'b0});
    applyStimulus(4'd5, 32'h5, 32'h7, 5'd4);
    checkOutput("sub_borrow", {32'hFFFF_FFFE, 5'd4, 1'b0, 1'b1, 1'b0});
    applyStimulus(4'd8, 32'h8000_0000, 32'h24, 5'd5);
    checkOutput("sra", {32'hF800_0000, 5'd5, 1'b0, 1'b0, 1'b0});
    applyStimulus(4'd9, 32'hFFFF_FFFF, 32'h1, 5'd6);
    checkOutput("slt", {32'h1, 5'd6, 1'b0, 1'b0, 1'b0});
    applyStimulus(4'd10, 32'hFFFF_FFFF, 32'h1, 5'd7);
    checkOutput("sltu", {32'h0, 5'd7, 1'b1, 1'b0, 1'b0});
    applyStimulus(4'd12, 32'h1234, 32'h0, 5'd8);
    checkOutput("invalid_op", {32'h0, 5'd8, 1'b1, 1'b0, 1'b1});

    // Back-to-back logic ops must come out on consecutive cycles.
    base = outCycles.size();
    for (int f = 0; f < 4; f++) applyStimulus(4'(f), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'(10 + f));
    repeat (4) @(negedge clk);
    checkBits("b2b_count", 64'(outCycles.size() - base), 64'(4));
    if (outCycles.size() - base == 4)
      checkBits("b2b_no_bubble", 64'(outCycles[base+3] - outCycles[base]), 64'(3));
    syncUp();

    // Stall: two ops fill the pipe, the third waits while outputs hold.
    bus.out_ready_i = 1'b0;
    base = popCount;
    applyStimulus(4'd4, 32'd10, 32'd20, 5'd7);
    applyStimulus(4'd2, 32'hFF, 32'h0F, 5'd8);
    bus.func_i      = 4'd5;
    bus.rs1_data_i  = 32'd100;
    bus.rs2_data_i  = 32'd1;
    bus.rd_addr_i   = 5'd9;
    bus.in_valid_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkBits("stall_in_ready", 64'(bus.in_ready_o), 64'(0));
      checkBits("stall_hold", 64'({bus.out_valid_o, bus.rd_data_o, bus.rd_addr_o}),
                64'({1'b1, 32'd30, 5'd7}));
      bus.rs1_data_i = $urandom;
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    applyStimulus(4'd5, 32'd100, 32'd1, 5'd9);
    repeat (4) @(negedge clk);
    checkBits("stall_drain_count", 64'(popCount - base), 64'(3));
    checkBits("stall_drain_empty", 64'(sbQueue.size()), 64'(0));
    syncUp();

    // Reset with both stages full discards everything in flight.
    bus.out_ready_i = 1'b0;
    applyStimulus(4'd0, 32'h1111_1111, 32'h0101_0101, 5'd1);
    applyStimulus(4'd1, 32'h2222_2222, 32'h0, 5'd2);
    @(negedge clk);
    checkBits("full_pipe", 64'({bus.out_valid_o, bus.in_ready_o}), 64'(2'b10));
    #2;
    arstN = 1'b0;
    #1;
    checkBits("async_reset_clear", 64'({bus.out_valid_o, bus.rd_data_o, bus.rd_addr_o,
                                        bus.zero_o, bus.carry_o, bus.invalid_o}), 64'(0));
    sbQueue.delete();
    @(posedge clk);
    @(negedge clk);
    arstN = 1'b1;
    #1;
    checkBits("reset_release", 64'({bus.in_ready_o, bus.out_valid_o}), 64'(2'b10));
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkBits("no_stale_output", 64'(bus.out_valid_o), 64'(0));
    end
    syncUp();

    randMode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        syncUp();
        bus.out_ready_i = 1'($urandom_range(0, 1));
      end
      applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(),
                    5'($urandom_range(0, 31)));
    end
    randMode = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 50 && sbQueue.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkBits("random_drain_empty", 64'(sbQueue.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined integer ALU with valid/ready handshakes on its input and output. It succeeds the combinational logic-gate ALU: it is generalised in data width and adds arithmetic, shift and compare operations, result flags, a destination-address sideband and backpressure. It sits between the decode/register-read stage and register-file writeback of the simple processor.

Parameters:
DATA_WIDTH, 32, operand/result width in bits; must be at least 8 and a power of two.
ADDR_WIDTH, 5, destination register address width.
FUNC_WIDTH, 4, opcode width; fixed encoding listed in Behaviour.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
arst_ni  in  1  asynchronous active-low reset.
in_valid_i  in  1  the input operation is valid.
in_ready_o  out  1  the block accepts an input this cycle.
rs1_data_i  in  DATA_WIDTH  operand A.
rs2_data_i  in  DATA_WIDTH  operand B, or the shift amount.
func_i  in  FUNC_WIDTH  opcode.
rd_addr_i  in  ADDR_WIDTH  destination register; passed through unchanged.
out_valid_o  out  1  the result is valid.
out_ready_i  in  1  downstream accepts the result.
rd_data_o  out  DATA_WIDTH  result.
rd_addr_o  out  ADDR_WIDTH  destination register paired with the result.
zero_o  out  1  result equals 0.
carry_o  out  1  ADD carry-out or SUB borrow; 0 for all other ops.
invalid_o  out  1  opcode was not recognised.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low, on clk_i and arst_ni.
- Outputs during reset: while arst_ni=0, out_valid_o=0 and rd_data_o, rd_addr_o, zero_o, carry_o and invalid_o are all 0.
- Input acceptance: an input transfer occurs when in_valid_i && in_ready_o.
- Output transfer: an output transfer occurs when out_valid_o && out_ready_i.
- Stage 1 (S1): registers the operands, opcode and address on every input transfer.
- Stage 2 (S2): registers the computed result, flags and address when S1 advances.
- Advance rules: s2_free = !s2_valid || out_ready_i. S1 advances when s1_valid && s2_free. in_ready_o = !s1_valid || s2_free.
  - in_ready_o is combinational from out_ready_i; this path is permitted.
- Latency and throughput: two cycles from input transfer to out_valid_o when there is no backpressure; throughput is one operation per cycle.
- Stall: while out_valid_o=1 and out_ready_i=0, all S2 outputs hold stable.
- Full pipeline: with both stages full and out_ready_i=0, in_ready_o=0 and S1 holds its contents.
- Simultaneous events: an output transfer, an S1→S2 advance and a new input transfer may all occur in the same cycle; no bubble is inserted.
- Valid clearing: if S1 empties without a new input, s1_valid clears; likewise for S2.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOT (~rs1).
  - 4 ADD, 5 SUB (rs1-rs2).
  - 6 SLL, 7 SRL, 8 SRA; shift amount = rs2[$clog2(DATA_WIDTH)-1:0].
  - 9 SLT (signed rs1<rs2 → 1, else 0), 10 SLTU (unsigned).
  - 11..15 invalid: result 0, invalid_o=1, zero_o=1, carry_o=0.
- Arithmetic: ADD and SUB wrap modulo 2^DATA_WIDTH.
  - ADD: carry_o = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum.
  - SUB: carry_o = 1 iff rs1 < rs2 unsigned (borrow).
- Flags: zero_o is computed from the registered result and is valid for every opcode.
- Reset mid-operation: in-flight operations in S1 and S2 are discarded; nothing is emitted after reset deasserts.
  - The first cycle with arst_ni=1 has in_ready_o=1 and out_valid_o=0.
- Input stability: inputs are sampled only on a transfer; changes while in_ready_o=0 have no effect.

Test Plan:
- Reset release → out_valid_o=0 and in_ready_o=1. Inject ADD 0xFFFFFFFF+0x00000001, rd=3, out_ready_i=1 → two cycles later: rd_data_o=0, zero_o=1, carry_o=1, rd_addr_o=3.
- SUB 0x5−0x7 → rd_data_o=0xFFFFFFFE, carry_o=1. SRA 0x80000000 by rs2=0x24 (amount 4) → 0xF8000000. SLT 0xFFFFFFFF vs 0x1 → 1. SLTU on the same operands → 0.
- Back-to-back AND, OR, XOR, NOT, funcs 0–3, on 0xF0F0F0F0/0x0FF00FF0 with out_ready_i=1 → results 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00, 0x0F0F0F0F on consecutive cycles, no bubbles.
- Hold out_ready_i=0 for 5 cycles while issuing 3 ops:
  - Required: the first 2 are accepted, then in_ready_o=0.
  - Required: rd_data_o and rd_addr_o are stable throughout the stall.
  - On release: all 3 results emerge in order with correct addresses, and no duplicates.
- func_i=12 with rs1=0x1234 → rd_data_o=0, invalid_o=1, zero_o=1, carry_o=0.
- Assert arst_ni=0 for 1 cycle while both stages are full → out_valid_o drops immediately (asynchronously); after release, no stale result appears within 5 cycles.
- Random 1000-op run with random out_ready_i against a reference model queue → 0 mismatches.
